watch_time_counter: RTL and testbench

//  Free-running calendar/time-of-day counter downstream of the watch set-mode block.

---
 rtl/watch_pkg.sv | 47 ++++
 rtl/watch_time_counter_if.sv | 25 ++
 rtl/watch_date_inc.sv | 35 +++
 rtl/watch_time_counter.sv | 109 ++++++++++
 tb/tb_watch_time_counter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-keeping blocks: bin_time layout,
// field limits and calendar helpers (also used by set mode).
package watch_pkg;

  localparam int TIME_W     = 52;
  localparam int YEAR_W     = 12;
  localparam int FIELD_W    = 8;
  localparam int YEAR_LSB   = 40;
  localparam int MONTH_LSB  = 32;
  localparam int DAY_LSB    = 24;
  localparam int HOUR_LSB   = 16;
  localparam int MINUTE_LSB = 8;
  localparam int SECOND_LSB = 0;

  localparam logic [7:0]  MAX_SECOND = 8'd59;
  localparam logic [7:0]  MAX_MINUTE = 8'd59;
  localparam logic [7:0]  MAX_HOUR   = 8'd23;
  localparam logic [7:0]  MAX_MONTH  = 8'd12;
  localparam logic [11:0] MAX_YEAR   = 12'd4095;

  // Field order matches the bin_time bus, so a cast gives the decoded view.
  typedef struct packed {
    logic [11:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
  } watch_time_t;

  function automatic logic is_leap(input logic [11:0] year);
    return ((year[1:0] == 2'b00) && ((year % 12'd100) != 12'd0)) ||
           ((year % 12'd400) == 12'd0);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                               input logic [11:0] year);
    logic [7:0] days;
    case (month)
      8'd4, 8'd6, 8'd9, 8'd11: days = 8'd30;
      8'd2:                    days = is_leap(year) ? 8'd29 : 8'd28;
      default:                 days = 8'd31;
    endcase
    return days;
  endfunction

endpackage

// File: rtl/watch_time_counter_if.sv
// Load/readback bus between set mode (master) and the time counter (slave).
interface watch_time_counter_if;

  logic                        en_time;
  logic [watch_pkg::TIME_W-1:0] bin_time;
  logic [11:0]                 year;
  logic [7:0]                  month;
  logic [7:0]                  day;
  logic [7:0]                  hour;
  logic [7:0]                  minute;
  logic [7:0]                  second;
  logic                        sec_tick;
  logic                        ld_err;

  modport master (
    output en_time, bin_time,
    input  year, month, day, hour, minute, second, sec_tick, ld_err
  );

  modport slave (
    input  en_time, bin_time,
    output year, month, day, hour, minute, second, sec_tick, ld_err
  );

endinterface

// File: rtl/watch_date_inc.sv
// Combinational next-date: advances the calendar date by one day when
// carry_in is set, with month/year rollover, leap years and year 4095->1 wrap.
module watch_date_inc
  import watch_pkg::*;
(
  input  logic [11:0] year_in,
  input  logic [7:0]  month_in,
  input  logic [7:0]  day_in,
  input  logic        carry_in,
  output logic [11:0] year_out,
  output logic [7:0]  month_out,
  output logic [7:0]  day_out
);

  always_comb begin
    year_out  = year_in;
    month_out = month_in;
    day_out   = day_in;
    if (carry_in) begin
      if (day_in >= days_in_month(month_in, year_in)) begin
        day_out = 8'd1;
        if (month_in >= MAX_MONTH) begin
          month_out = 8'd1;
          // Year 0 is not a valid date, so the top year wraps to 1.
          year_out  = (year_in == MAX_YEAR) ? 12'd1 : year_in + 12'd1;
        end else begin
          month_out = month_in + 8'd1;
        end
      end else begin
        day_out = day_in + 8'd1;
      end
    end
  end

endmodule

// File: rtl/watch_time_counter.sv
// Calendar/time-of-day counter: advances one second per clk1sec rising edge
// and accepts validated loads from set mode.
module watch_time_counter
  import watch_pkg::*;
#(
  parameter logic [11:0] RST_YEAR   = 12'd2000,
  parameter logic [7:0]  RST_MONTH  = 8'd1,
  parameter logic [7:0]  RST_DAY    = 8'd1,
  parameter logic [7:0]  RST_HOUR   = 8'd0,
  parameter logic [7:0]  RST_MINUTE = 8'd0,
  parameter logic [7:0]  RST_SECOND = 8'd0
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk1sec,
  watch_time_counter_if.slave  bus
);

  localparam watch_time_t RST_TIME =
    {RST_YEAR, RST_MONTH, RST_DAY, RST_HOUR, RST_MINUTE, RST_SECOND};

  logic        sync1, sync2, sync3;
  logic        tick;
  watch_time_t cur, nxt, ld;
  logic        ld_valid;
  logic        sec_wrap, min_wrap, hour_wrap;
  logic [11:0] inc_year;
  logic [7:0]  inc_month, inc_day;
  logic        sec_tick_q, ld_err_q;

  // clk1sec is asynchronous: two flops to resolve metastability, a third for the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= clk1sec;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign tick = sync2 & ~sync3;

  assign sec_wrap  = (cur.second >= MAX_SECOND);
  assign min_wrap  = sec_wrap && (cur.minute >= MAX_MINUTE);
  assign hour_wrap = min_wrap && (cur.hour >= MAX_HOUR);

  watch_date_inc u_date_inc (
    .year_in   (cur.year),
    .month_in  (cur.month),
    .day_in    (cur.day),
    .carry_in  (hour_wrap),
    .year_out  (inc_year),
    .month_out (inc_month),
    .day_out   (inc_day)
  );

  always_comb begin
    nxt        = cur;
    nxt.second = sec_wrap ? 8'd0 : cur.second + 8'd1;
    if (sec_wrap) nxt.minute = min_wrap ? 8'd0 : cur.minute + 8'd1;
    if (min_wrap) nxt.hour = hour_wrap ? 8'd0 : cur.hour + 8'd1;
    nxt.year  = inc_year;
    nxt.month = inc_month;
    nxt.day   = inc_day;
  end

  assign ld = watch_time_t'(bus.bin_time);

  // Day limit is taken from the loaded month/year, not the current one.
  assign ld_valid = (ld.year != 12'd0) &&
                    (ld.month >= 8'd1) && (ld.month <= MAX_MONTH) &&
                    (ld.day >= 8'd1) && (ld.day <= days_in_month(ld.month, ld.year)) &&
                    (ld.hour <= MAX_HOUR) &&
                    (ld.minute <= MAX_MINUTE) &&
                    (ld.second <= MAX_SECOND);

  // A load strobe, accepted or not, swallows any coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur        <= RST_TIME;
      sec_tick_q <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      ld_err_q   <= 1'b0;
      if (bus.en_time) begin
        if (ld_valid) cur <= ld;
        else          ld_err_q <= 1'b1;
      end else if (tick) begin
        cur        <= nxt;
        sec_tick_q <= 1'b1;
      end
    end
  end

  assign bus.year     = cur.year;
  assign bus.month    = cur.month;
  assign bus.day      = cur.day;
  assign bus.hour     = cur.hour;
  assign bus.minute   = cur.minute;
  assign bus.second   = cur.second;
  assign bus.sec_tick = sec_tick_q;
  assign bus.ld_err   = ld_err_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter: table of load/advance vectors, hand-built
// corner sequences and random loads checked against a calendar model.
module tb_watch_time_counter;
  import watch_pkg::*;

  logic clk;
  logic rst;
  logic clk1sec;

  watch_time_counter_if bus ();

  watch_time_counter dut (
    .clk     (clk),
    .rst     (rst),
    .clk1sec (clk1sec),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    watch_time_t start;
    bit          accept;
    watch_time_t after;
  } vec_t;

  vec_t        vecs[$];
  watch_time_t exp_cur;
  watch_time_t rst_time;
  int          special_years[6] = '{1900, 2000, 2100, 2400, 2024, 4095};

  function automatic watch_time_t mk(int y, int mo, int d, int h, int mi, int s);
    return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  function automatic vec_t mkv(string n, watch_time_t st, bit acc, watch_time_t af);
    vec_t v;
    v.name = n; v.start = st; v.accept = acc; v.after = af;
    return v;
  endfunction

  // Calendar reference model, worked in plain integers.
  function automatic int m_dim(int mo, int y);
    int tbl[12];
    bit lp;
    tbl = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    lp  = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (mo < 1 || mo > 12) return 0;
    return tbl[mo-1] + ((mo == 2 && lp) ? 1 : 0);
  endfunction

  function automatic bit m_valid(watch_time_t t);
    int y, mo, d;
    y = int'(t.year); mo = int'(t.month); d = int'(t.day);
    return (y >= 1) && (y <= 4095) && (mo >= 1) && (mo <= 12) &&
           (d >= 1) && (d <= m_dim(mo, y)) &&
           (int'(t.hour) < 24) && (int'(t.minute) < 60) && (int'(t.second) < 60);
  endfunction

  function automatic watch_time_t m_advance(watch_time_t t);
    int y, mo, d, sod;
    y   = int'(t.year); mo = int'(t.month); d = int'(t.day);
    sod = int'(t.hour) * 3600 + int'(t.minute) * 60 + int'(t.second) + 1;
    if (sod == 86400) begin
      sod = 0;
      d   = d + 1;
      if (d > m_dim(mo, y)) begin
        d  = 1;
        mo = mo + 1;
        if (mo > 12) begin
          mo = 1;
          y  = (y == 4095) ? 1 : y + 1;
        end
      end
    end
    return mk(y, mo, d, sod / 3600, (sod / 60) % 60, sod % 60);
  endfunction

  task automatic checkOutput(input string name, input watch_time_t exp,
                             input logic exp_tick, input logic exp_err);
    watch_time_t act;
    act = {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second};
    n_checks++;
    if (act !== exp || bus.sec_tick !== exp_tick || bus.ld_err !== exp_err) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d-%0d-%0d %0d:%0d:%0d tick=%b err=%b, expected %0d-%0d-%0d %0d:%0d:%0d tick=%b err=%b",
               name, act.year, act.month, act.day, act.hour, act.minute, act.second,
               bus.sec_tick, bus.ld_err, exp.year, exp.month, exp.day, exp.hour,
               exp.minute, exp.second, exp_tick, exp_err);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d pulses, expected %0d", name, got, exp);
    end
  endtask

  // One-cycle load strobe, entered and left on a falling clk edge.
  task automatic applyStimulus(input watch_time_t t);
    bus.en_time  = 1'b1;
    bus.bin_time = t;
    @(negedge clk);
    bus.en_time  = 1'b0;
  endtask

  // One clk1sec rising edge: old value two clocks in, new value on the third.
  task automatic tick_once(input string name, input watch_time_t prev, input watch_time_t nxt);
    clk1sec = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput({name, "_pre"}, prev, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput(name, nxt, 1'b1, 1'b0);
    clk1sec = 1'b0;
    @(negedge clk);
    checkOutput({name, "_post"}, nxt, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    watch_time_t a, b, c;
    int pulses;

    rst_time     = mk(2000, 1, 1, 0, 0, 0);
    rst          = 1'b0;
    clk1sec      = 1'b0;
    bus.en_time  = 1'b0;
    bus.bin_time = '0;

    // Table: {load, accepted?, value after one tick} with hand-worked results.
    vecs.push_back(mkv("rollover",  mk(1999,12,31,23,59,59), 1, mk(2000,1,1,0,0,0)));
    vecs.push_back(mkv("leap_2024", mk(2024,2,28,23,59,59),  1, mk(2024,2,29,0,0,0)));
    vecs.push_back(mkv("leap_2100", mk(2100,2,28,23,59,59),  1, mk(2100,3,1,0,0,0)));
    vecs.push_back(mkv("leap_2000", mk(2000,2,28,23,59,59),  1, mk(2000,2,29,0,0,0)));
    vecs.push_back(mkv("feb29_end", mk(2024,2,29,23,59,59),  1, mk(2024,3,1,0,0,0)));
    vecs.push_back(mkv("year_wrap", mk(4095,12,31,23,59,59), 1, mk(1,1,1,0,0,0)));
    vecs.push_back(mkv("apr30",     mk(2023,4,30,12,0,0),    1, mk(2023,4,30,12,0,1)));
    vecs.push_back(mkv("apr_end",   mk(2023,4,30,23,59,59),  1, mk(2023,5,1,0,0,0)));
    vecs.push_back(mkv("hour_carry",mk(2023,6,15,10,59,59),  1, mk(2023,6,15,11,0,0)));
    vecs.push_back(mkv("rej_feb29", mk(2023,2,29,0,0,0),     0, '0));
    vecs.push_back(mkv("rej_apr31", mk(2023,4,31,0,0,0),     0, '0));
    vecs.push_back(mkv("rej_month", mk(2023,13,1,0,0,0),     0, '0));
    vecs.push_back(mkv("rej_year0", mk(0,1,1,0,0,0),         0, '0));
    vecs.push_back(mkv("rej_day0",  mk(2023,5,0,0,0,0),      0, '0));
    vecs.push_back(mkv("rej_hour",  mk(2023,5,1,24,0,0),     0, '0));
    vecs.push_back(mkv("rej_min",   mk(2023,5,1,0,60,0),     0, '0));
    vecs.push_back(mkv("rej_sec",   mk(2023,5,1,0,0,60),     0, '0));

    repeat (3) @(negedge clk);
    checkOutput("reset_hold", rst_time, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_release", rst_time, 1'b0, 1'b0);
    exp_cur = rst_time;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start);
      if (vecs[i].accept) begin
        checkOutput({vecs[i].name, "_load"}, vecs[i].start, 1'b0, 1'b0);
        tick_once(vecs[i].name, vecs[i].start, vecs[i].after);
        exp_cur = vecs[i].after;
      end else begin
        checkOutput(vecs[i].name, exp_cur, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput({vecs[i].name, "_clear"}, exp_cur, 1'b0, 1'b0);
      end
    end

    // Load lands in the same clock as the tick: load wins, tick discarded.
    a = mk(2023, 6, 15, 10, 20, 30);
    b = mk(2022, 11, 5, 8, 7, 6);
    applyStimulus(a);
    checkOutput("collision_setup", a, 1'b0, 1'b0);
    clk1sec = 1'b1;
    repeat (2) @(negedge clk);
    bus.en_time  = 1'b1;
    bus.bin_time = b;
    @(negedge clk);
    bus.en_time = 1'b0;
    checkOutput("collision", b, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("collision_hold", b, 1'b0, 1'b0);
    clk1sec = 1'b0;
    repeat (4) @(negedge clk);
    tick_once("collision_next", b, mk(2022, 11, 5, 8, 7, 7));

    // en_time held across a whole clk1sec rise keeps reloading and drops the tick.
    c = mk(2021, 1, 31, 23, 59, 59);
    bus.en_time  = 1'b1;
    bus.bin_time = c;
    clk1sec      = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("en_held", c, 1'b0, 1'b0);
    end
    bus.en_time = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("en_held_after", c, 1'b0, 1'b0);
    clk1sec = 1'b0;
    repeat (4) @(negedge clk);
    tick_once("en_held_next", c, mk(2021, 2, 1, 0, 0, 0));

    // clk1sec held high for a long time gives exactly one advance.
    a = mk(2023, 4, 30, 12, 0, 0);
    applyStimulus(a);
    clk1sec = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.sec_tick === 1'b1) pulses++;
    end
    clk1sec = 1'b0;
    checkCount("held_high_pulses", pulses, 1);
    checkOutput("held_high_value", mk(2023, 4, 30, 12, 0, 1), 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    exp_cur = mk(2023, 4, 30, 12, 0, 1);

    // Random loads (some invalid) followed by a few ticks, against the model.
    for (int i = 0; i < 40; i++) begin
      int y, mo, d, h, mi, s, nt;
      watch_time_t t, nx;
      bit acc;
      y  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4095))
                                       : special_years[$urandom_range(0, 5)];
      mo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) * 13
                                       : int'($urandom_range(1, 12));
      d  = ($urandom_range(0, 1) == 0) ? m_dim(mo, y) : int'($urandom_range(0, 31));
      h  = ($urandom_range(0, 1) == 0) ? 23 : int'($urandom_range(0, 24));
      mi = ($urandom_range(0, 1) == 0) ? 59 : int'($urandom_range(0, 60));
      s  = ($urandom_range(0, 1) == 0) ? 59 : int'($urandom_range(0, 60));
      t   = mk(y, mo, d, h, mi, s);
      acc = m_valid(t);
      applyStimulus(t);
      if (acc) exp_cur = t;
      checkOutput("rand_load", exp_cur, 1'b0, !acc);
      nt = int'($urandom_range(1, 3));
      for (int k = 0; k < nt; k++) begin
        nx = m_advance(exp_cur);
        tick_once("rand_tick", exp_cur, nx);
        exp_cur = nx;
      end
    end

    // Reset during a pending tick: immediate return to reset values, tick lost.
    a = mk(2023, 7, 4, 5, 6, 7);
    applyStimulus(a);
    checkOutput("midreset_setup", a, 1'b0, 1'b0);
    clk1sec = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midreset_async", rst_time, 1'b0, 1'b0);
    clk1sec = 1'b0;
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.sec_tick === 1'b1) pulses++;
    end
    checkCount("midreset_pulses", pulses, 0);
    checkOutput("midreset_value", rst_time, 1'b0, 1'b0);
    tick_once("midreset_first_tick", rst_time, mk(2000, 1, 1, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
